// File: rtl/env_ctrl_pkg.sv
// Shared types and helpers for the environmental actuator controller.
// Each channel runs the same hysteresis FSM; the encoding is visible on the status ports.
package env_ctrl_pkg;

   localparam logic [1:0] ST_IDLE_ENC     = 2'd0;
   localparam logic [1:0] ST_LOW_ACT_ENC  = 2'd1;
   localparam logic [1:0] ST_HIGH_ACT_ENC = 2'd2;
   localparam logic [1:0] ST_LOCKOUT_ENC  = 2'd3;

   typedef enum logic [1:0] {
      IDLE     = ST_IDLE_ENC,
      LOW_ACT  = ST_LOW_ACT_ENC,
      HIGH_ACT = ST_HIGH_ACT_ENC,
      LOCKOUT  = ST_LOCKOUT_ENC
   } chan_state_t;

   // Band midpoint; the 32-bit sum cannot overflow for any sample width up to 31 bits.
   function automatic logic [31:0] mid_calc(input logic [31:0] lo, input logic [31:0] hi);
      logic [31:0] sum;
      sum = lo + hi;
      return sum >> 1;
   endfunction

endpackage

// File: rtl/env_hyst_chan.sv
// One hysteresis channel: enters LOW/HIGH when a sample leaves the band, exits at the
// band midpoint only after the minimum on-time, then holds a lockout before re-arming.
module env_hyst_chan
   import env_ctrl_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int MIN_ON_CYC  = 16,
   parameter int MIN_OFF_CYC = 8
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic              i_ctrl_en,
   input  logic              i_sample_valid,
   input  logic [DATA_W-1:0] i_val,
   input  logic [DATA_W-1:0] i_lo,
   input  logic [DATA_W-1:0] i_hi,
   output logic              o_low,
   output logic              o_high,
   output logic [1:0]        o_state,
   output logic              o_cfg_err
);

   localparam int CNT_MAX = (MIN_ON_CYC > MIN_OFF_CYC) ? MIN_ON_CYC : MIN_OFF_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] ON_MAX   = CNT_W'(MIN_ON_CYC);
   localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(MIN_OFF_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   chan_state_t      r_state;
   logic [CNT_W-1:0] r_on_cnt;
   logic [CNT_W-1:0] r_off_cnt;
   logic             r_cfg_err;

   logic        w_bad;
   logic [31:0] w_mid;
   logic        w_ge_mid;
   logic        w_le_mid;
   logic        w_on_done;

   assign w_bad     = (i_lo >= i_hi);
   assign w_mid     = mid_calc(32'(i_lo), 32'(i_hi));
   assign w_ge_mid  = (32'(i_val) >= w_mid);
   assign w_le_mid  = (32'(i_val) <= w_mid);
   assign w_on_done = (r_on_cnt == ON_MAX);

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_state   <= IDLE;
         r_on_cnt  <= '0;
         r_off_cnt <= '0;
         r_cfg_err <= 1'b0;
      end else begin
         r_cfg_err <= w_bad;
         // Bad thresholds or global disable abort immediately, bypassing on-time and lockout.
         if (w_bad || !i_ctrl_en) begin
            r_state   <= IDLE;
            r_on_cnt  <= '0;
            r_off_cnt <= '0;
         end else begin
            case (r_state)
               IDLE: begin
                  r_on_cnt  <= '0;
                  r_off_cnt <= '0;
                  if (i_sample_valid) begin
                     if (i_val < i_lo)      r_state <= LOW_ACT;
                     else if (i_val > i_hi) r_state <= HIGH_ACT;
                  end
               end
               LOW_ACT, HIGH_ACT: begin
                  if (!w_on_done) r_on_cnt <= r_on_cnt + CNT_ONE;
                  if (i_sample_valid && w_on_done &&
                      ((r_state == LOW_ACT) ? w_ge_mid : w_le_mid)) begin
                     r_state   <= LOCKOUT;
                     r_on_cnt  <= '0;
                     r_off_cnt <= '0;
                  end
               end
               LOCKOUT: begin
                  if (r_off_cnt == OFF_LAST) begin
                     r_state   <= IDLE;
                     r_off_cnt <= '0;
                  end else begin
                     r_off_cnt <= r_off_cnt + CNT_ONE;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign o_low     = (r_state == LOW_ACT);
   assign o_high    = (r_state == HIGH_ACT);
   assign o_state   = r_state;
   assign o_cfg_err = r_cfg_err;

endmodule

// File: rtl/env_actuator_ctrl.sv
// Temperature and humidity hysteresis control producing the four actuator enables.
// The two channels are independent; only the config-error flag is shared.
module env_actuator_ctrl
   import env_ctrl_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int MIN_ON_CYC  = 16,
   parameter int MIN_OFF_CYC = 8
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic              ctrl_en,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] temp_val,
   input  logic [DATA_W-1:0] hum_val,
   input  logic [DATA_W-1:0] temp_lo,
   input  logic [DATA_W-1:0] temp_hi,
   input  logic [DATA_W-1:0] hum_lo,
   input  logic [DATA_W-1:0] hum_hi,
   output logic              heater_en,
   output logic              fan_en,
   output logic              humidifier_en,
   output logic              dehumidifier_en,
   output logic [1:0]        temp_state,
   output logic [1:0]        hum_state,
   output logic              cfg_err
);

   logic w_temp_err;
   logic w_hum_err;

   env_hyst_chan #(
      .DATA_W(DATA_W), .MIN_ON_CYC(MIN_ON_CYC), .MIN_OFF_CYC(MIN_OFF_CYC)
   ) u_temp (
      .pclk           (pclk),
      .presetn        (presetn),
      .i_ctrl_en      (ctrl_en),
      .i_sample_valid (sample_valid),
      .i_val          (temp_val),
      .i_lo           (temp_lo),
      .i_hi           (temp_hi),
      .o_low          (heater_en),
      .o_high         (fan_en),
      .o_state        (temp_state),
      .o_cfg_err      (w_temp_err)
   );

   env_hyst_chan #(
      .DATA_W(DATA_W), .MIN_ON_CYC(MIN_ON_CYC), .MIN_OFF_CYC(MIN_OFF_CYC)
   ) u_hum (
      .pclk           (pclk),
      .presetn        (presetn),
      .i_ctrl_en      (ctrl_en),
      .i_sample_valid (sample_valid),
      .i_val          (hum_val),
      .i_lo           (hum_lo),
      .i_hi           (hum_hi),
      .o_low          (humidifier_en),
      .o_high         (dehumidifier_en),
      .o_state        (hum_state),
      .o_cfg_err      (w_hum_err)
   );

   assign cfg_err = w_temp_err | w_hum_err;

endmodule

// File: tb/tb_env_actuator_ctrl.sv
// Directed bench for env_actuator_ctrl: MIN_ON_CYC=4, MIN_OFF_CYC=2, temp band 20..30,
// humidity band 40..60. Observed vector = {heater,fan,humid,dehum,temp_state,hum_state,cfg_err}.
module tb_env_actuator_ctrl;

   logic       pclk = 1'b0;
   logic       presetn;
   logic       ctrl_en;
   logic       sample_valid;
   logic [7:0] temp_val, hum_val, temp_lo, temp_hi, hum_lo, hum_hi;
   logic       heater_en, fan_en, humidifier_en, dehumidifier_en, cfg_err;
   logic [1:0] temp_state, hum_state;

   int n_cmp = 0;
   int n_err = 0;

   env_actuator_ctrl #(.DATA_W(8), .MIN_ON_CYC(4), .MIN_OFF_CYC(2)) dut (
      .pclk(pclk), .presetn(presetn), .ctrl_en(ctrl_en), .sample_valid(sample_valid),
      .temp_val(temp_val), .hum_val(hum_val), .temp_lo(temp_lo), .temp_hi(temp_hi),
      .hum_lo(hum_lo), .hum_hi(hum_hi), .heater_en(heater_en), .fan_en(fan_en),
      .humidifier_en(humidifier_en), .dehumidifier_en(dehumidifier_en),
      .temp_state(temp_state), .hum_state(hum_state), .cfg_err(cfg_err)
   );

   always #5 pclk = ~pclk;

   function automatic logic [8:0] ev(input logic h, input logic f, input logic hu, input logic d,
                                     input logic [1:0] ts, input logic [1:0] hs, input logic ce);
      return {h, f, hu, d, ts, hs, ce};
   endfunction

   task automatic chk(input string tag, input logic [8:0] exp_v);
      logic [8:0] obs;
      obs = {heater_en, fan_en, humidifier_en, dehumidifier_en, temp_state, hum_state, cfg_err};
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic pulse(input logic [7:0] t, input logic [7:0] h);
      temp_val = t;
      hum_val  = h;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
   endtask

   initial begin
      presetn = 1'b0; ctrl_en = 1'b1; sample_valid = 1'b0;
      temp_val = 8'd25; hum_val = 8'd50;
      temp_lo = 8'd20; temp_hi = 8'd30; hum_lo = 8'd40; hum_hi = 8'd60;
      #2;
      chk("reset", ev(0,0,0,0,2'd0,2'd0,0));
      #1 presetn = 1'b1;
      tick();
      chk("idle_after_reset", ev(0,0,0,0,2'd0,2'd0,0));

      // basic heat cycle
      pulse(8'd15, 8'd50);
      chk("heat_on", ev(1,0,0,0,2'd1,2'd0,0));
      repeat (4) tick();
      chk("heat_held", ev(1,0,0,0,2'd1,2'd0,0));
      pulse(8'd26, 8'd50);
      chk("heat_exit_lockout", ev(0,0,0,0,2'd3,2'd0,0));
      tick();
      chk("lockout_1", ev(0,0,0,0,2'd3,2'd0,0));
      tick();
      chk("lockout_done", ev(0,0,0,0,2'd0,2'd0,0));

      // minimum on-time on the fan
      pulse(8'd35, 8'd50);
      chk("fan_on", ev(0,1,0,0,2'd2,2'd0,0));
      pulse(8'd22, 8'd50);
      chk("fan_early_ignored", ev(0,1,0,0,2'd2,2'd0,0));
      repeat (2) tick();
      pulse(8'd22, 8'd50);
      chk("fan_cnt3_ignored", ev(0,1,0,0,2'd2,2'd0,0));
      pulse(8'd22, 8'd50);
      chk("fan_off", ev(0,0,0,0,2'd3,2'd0,0));
      repeat (2) tick();
      chk("fan_lockout_done", ev(0,0,0,0,2'd0,2'd0,0));

      // boundaries
      pulse(8'd20, 8'd40);
      chk("eq_lo_idle", ev(0,0,0,0,2'd0,2'd0,0));
      pulse(8'd30, 8'd60);
      chk("eq_hi_idle", ev(0,0,0,0,2'd0,2'd0,0));
      pulse(8'd15, 8'd50);
      repeat (4) tick();
      pulse(8'd24, 8'd50);
      chk("below_mid_hold", ev(1,0,0,0,2'd1,2'd0,0));
      pulse(8'd25, 8'd50);
      chk("at_mid_exit", ev(0,0,0,0,2'd3,2'd0,0));
      repeat (2) tick();
      pulse(8'd31, 8'd50);
      repeat (4) tick();
      pulse(8'd26, 8'd50);
      chk("above_mid_fan_hold", ev(0,1,0,0,2'd2,2'd0,0));
      pulse(8'd25, 8'd50);
      chk("at_mid_fan_exit", ev(0,0,0,0,2'd3,2'd0,0));
      repeat (2) tick();

      // config error on temperature only
      pulse(8'd15, 8'd20);
      chk("both_low", ev(1,0,1,0,2'd1,2'd1,0));
      temp_lo = 8'd30;
      tick();
      chk("cfg_err_abort", ev(0,0,1,0,2'd0,2'd1,1));
      pulse(8'd15, 8'd20);
      chk("cfg_err_persist", ev(0,0,1,0,2'd0,2'd1,1));
      temp_lo = 8'd20;
      tick();
      chk("cfg_err_clear", ev(0,0,1,0,2'd0,2'd1,0));
      pulse(8'd35, 8'd20);
      chk("fan_and_humid", ev(0,1,1,0,2'd2,2'd1,0));

      // global disable
      ctrl_en = 1'b0;
      tick();
      chk("ctrl_en_drop", ev(0,0,0,0,2'd0,2'd0,0));
      pulse(8'd15, 8'd5);
      chk("ctrl_en_hold_idle", ev(0,0,0,0,2'd0,2'd0,0));
      ctrl_en = 1'b1;
      pulse(8'd25, 8'd5);
      chk("humid_after_enable", ev(0,0,1,0,2'd0,2'd1,0));

      // async reset while temperature is in lockout
      pulse(8'd15, 8'd5);
      repeat (4) tick();
      pulse(8'd26, 8'd5);
      chk("pre_reset_lockout", ev(0,0,1,0,2'd3,2'd1,0));
      #1 presetn = 1'b0;
      #1;
      chk("async_reset", ev(0,0,0,0,2'd0,2'd0,0));
      #1 presetn = 1'b1;
      pulse(8'd35, 8'd70);
      chk("post_reset_sample", ev(0,1,0,1,2'd2,2'd2,0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/env_actuator_ctrl.md
# env_actuator_ctrl

Hysteresis controller that turns temperature and humidity samples into the four actuator enables (`heater_en`, `fan_en`, `humidifier_en`, `dehumidifier_en`). The LED blinker stage downstream consumes these enables, and the same enables drive the actuator outputs. Samples and thresholds come from the sensor front-end and APB register file on the same `pclk` domain. Each physical quantity runs its own independent channel state machine, with minimum-on and minimum-off timers that prevent relay chatter.

## Interface
- `DATA_W`, 8: sample and threshold width (unsigned).
- `MIN_ON_CYC`, 16: minimum cycles an actuator stays on once enabled (≥1).
- `MIN_OFF_CYC`, 8: lockout cycles after an actuator turns off (≥1).

- `pclk`  in  1  system clock; the single clock.
- `presetn`  in  1  asynchronous, active-low reset.
- `ctrl_en`  in  1  global enable; low forces all actuators off.
- `sample_valid`  in  1  one-cycle pulse; `temp_val` and `hum_val` are valid.
- `temp_val`  in  DATA_W  temperature sample.
- `hum_val`  in  DATA_W  humidity sample.
- `temp_lo`, `temp_hi`  in  DATA_W  temperature band.
- `hum_lo`, `hum_hi`  in  DATA_W  humidity band.
- `heater_en`  out  1  temperature below band.
- `fan_en`  out  1  temperature above band.
- `humidifier_en`  out  1  humidity below band.
- `dehumidifier_en`  out  1  humidity above band.
- `temp_state`, `hum_state`  out  2  channel FSM state, for debug and status registers.
- `cfg_err`  out  1  any channel has lo ≥ hi.

## Operation
- Two identical channels: temperature (LOW → `heater_en`, HIGH → `fan_en`) and humidity (LOW → `humidifier_en`, HIGH → `dehumidifier_en`).
- Channel states: IDLE=0, LOW_ACT=1, HIGH_ACT=2, LOCKOUT=3.
- Midpoint: `mid = (lo + hi) >> 1`, computed at DATA_W+1 bits, with no overflow.
- IDLE:
  - On `sample_valid`, go to LOW_ACT if `val < lo`.
  - Else go to HIGH_ACT if `val > hi`.
  - Else stay in IDLE.
  - `val == lo` or `val == hi` means stay in IDLE.
- LOW_ACT:
  - `on_cnt` increments each cycle and saturates at MIN_ON_CYC.
  - On `sample_valid` with `on_cnt == MIN_ON_CYC` and `val >= mid`, go to LOCKOUT.
  - Samples that arrive before the minimum on-time has elapsed are ignored (no deferred exit).
- HIGH_ACT: symmetric to LOW_ACT, with the exit condition `val <= mid`.
- LOCKOUT:
  - Outputs are off and samples are ignored.
  - `off_cnt` counts to MIN_OFF_CYC, then the channel goes to IDLE.
- Per-channel `cfg_err` (lo ≥ hi), or `ctrl_en == 0`, forces that channel to IDLE on the next edge.
  - Counters clear and outputs go off.
  - This overrides the minimum on-time and skips LOCKOUT.
  - While the condition persists, the channel stays in IDLE.
- Invariant: LOW and HIGH enables of one channel are never both 1.
- Counters are sized to `$clog2(max(MIN_ON_CYC, MIN_OFF_CYC) + 1)` bits and reset to 0 on every state entry.

## Timing
- All outputs are registered.
- Reset values: all enables 0, `temp_state` = `hum_state` = 0, `cfg_err` 0, counters 0.
- Latency: a `sample_valid` at edge N produces the state and enable change visible after edge N.
  - Enables are a decode of the state register, so there is no additional cycle.
- `cfg_err` is registered and follows threshold changes with 1-cycle latency.
- Threshold changes take effect on the next evaluated sample; there is no shadowing.
- Back-to-back `sample_valid` pulses are allowed; each one is evaluated independently.
- Reset asserted mid-operation clears everything asynchronously, with no lockout after release.
- The channels are fully independent; simultaneous transitions on both channels are legal.

## Structure
- Package `env_ctrl_pkg` holds:
  - `chan_state_t` enum (IDLE, LOW_ACT, HIGH_ACT, LOCKOUT);
  - state-encoding constants;
  - the `mid` computation function.
- Sub-module `env_hyst_chan` (FSM, counters, midpoint, `cfg_err`) is instantiated twice.
- The top level maps each channel's LOW/HIGH outputs to the enables and ORs the two `cfg_err` signals.

## Test plan
Common setup: `temp_lo=20`, `temp_hi=30`, MIN_ON_CYC=4, MIN_OFF_CYC=2.

- **Basic heat cycle:** sample `temp=15`.
  - `heater_en=1` the next cycle and `temp_state=1`.
  - A sample of `temp=26` at on-cycle 5 drives `heater_en=0` and `temp_state=3`.
  - `temp_state=0` follows 2 cycles later.
- **Minimum on-time:** sample `temp=35` → `fan_en=1`.
  - `temp=22` one cycle later is ignored and `fan_en` stays 1.
  - `temp=22` after 4 cycles turns the fan off.
- **Boundaries:**
  - `temp=20` or `temp=30` from IDLE leaves the enables at 0.
  - In LOW_ACT, `temp=24` (below mid=25) keeps the heater on; `temp=25` exits.
- **Config error:** during active heating, set `temp_lo=30`, `temp_hi=30`.
  - `cfg_err=1` and `heater_en=0` within 2 cycles, `temp_state=0`.
  - Humidity channel is unaffected.
- **`ctrl_en` drop:** deassert `ctrl_en` while both channels are active → all enables 0 the next cycle with no LOCKOUT. Reassert, then sample `hum=5` with `hum_lo=40` → `humidifier_en=1`.
- **Reset mid-operation:** pulse `presetn` low asynchronously while in LOCKOUT → all outputs and states are 0 immediately, and a sample right after release is evaluated from IDLE.
